ll_free_ptr_fifo: RTL and testbench

LL_FREE_PTR_FIFO -- requirements
Module: ll_free_ptr_fifo

---
 rtl/ll_pkg.sv | 14 +
 rtl/ll_ptr_ram.sv | 31 +++
 rtl/ll_free_ptr_fifo.sv | 156 +++++++++++++++
 tb/tb_ll_free_ptr_fifo.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ll_pkg.sv
// Shared linked-list types: pool FSM state and the sticky error flags.
package ll_pkg;

    typedef enum logic [0:0] {
        LL_INIT = 1'b0,
        LL_RUN  = 1'b1
    } ll_state_e;

    typedef struct packed {
        logic ovf;
        logic unf;
    } ll_err_t;

endpackage

// File: rtl/ll_ptr_ram.sv
// Simple dual-port pointer storage, one write and one registered read port.
module ll_ptr_ram #(
    parameter int A_WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               wr_en_i,
    input  logic [A_WIDTH-1:0] wr_addr_i,
    input  logic [A_WIDTH-1:0] wr_data_i,
    input  logic               rd_en_i,
    input  logic [A_WIDTH-1:0] rd_addr_i,
    output logic [A_WIDTH-1:0] rd_data_o
);

    localparam int DEPTH = 2**A_WIDTH;

    logic [A_WIDTH-1:0] mem_q [DEPTH];
    logic [A_WIDTH-1:0] rd_data_q;

    // The read register only updates on rd_en_i, so it doubles as the FIFO head.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ll_free_ptr_fifo.sv
// Free-pointer pool: preloads pointers 0..INIT_CNT-1, then hands them out FWFT and accepts returns.
module ll_free_ptr_fifo
    import ll_pkg::*;
#(
    parameter int A_WIDTH  = 8,
    parameter int INIT_CNT = 2**A_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               srst_i,
    input  logic [A_WIDTH-1:0] add_empty_ptr_i,
    input  logic               add_empty_ptr_en_i,
    input  logic               next_empty_ptr_rd_ack_i,
    output logic [A_WIDTH-1:0] next_empty_ptr_o,
    output logic               next_empty_ptr_val_o,
    output logic               init_done_o,
    output logic [A_WIDTH:0]   free_cnt_o,
    output logic               ovf_o,
    output logic               unf_o
);

    localparam int               DEPTH     = 2**A_WIDTH;
    localparam logic [A_WIDTH:0] DEPTH_C   = (A_WIDTH+1)'(DEPTH);
    localparam logic [A_WIDTH:0] INIT_LAST = (A_WIDTH+1)'((INIT_CNT == 0) ? 0 : INIT_CNT - 1);

    ll_state_e          state_q,    state_d;
    logic [A_WIDTH-1:0] wr_idx_q,   wr_idx_d;
    logic [A_WIDTH-1:0] rd_idx_q,   rd_idx_d;
    logic [A_WIDTH:0]   ram_cnt_q,  ram_cnt_d;
    logic [A_WIDTH:0]   init_cnt_q, init_cnt_d;
    logic               val_q,      val_d;
    ll_err_t            err_q,      err_d;

    logic               run;
    logic               pop;
    logic               full;
    logic               add_acc;
    logic               rd_en;
    logic               init_wr;
    logic               ram_wr_en;
    logic [A_WIDTH-1:0] ram_wr_data;
    logic [A_WIDTH-1:0] ram_rd_data;
    logic [A_WIDTH:0]   free_cnt;

    // Pointers in RAM plus the one sitting in the head register.
    assign free_cnt = ram_cnt_q + (A_WIDTH+1)'(val_q);

    assign run     = (state_q == LL_RUN) && !srst_i;
    assign pop     = run && next_empty_ptr_rd_ack_i && val_q;
    assign full    = (free_cnt == DEPTH_C);
    assign add_acc = run && add_empty_ptr_en_i && (!full || pop);
    assign rd_en   = run && (ram_cnt_q != '0) && (!val_q || pop);
    assign init_wr = (state_q == LL_INIT) && !srst_i && (INIT_CNT != 0);

    assign ram_wr_en   = init_wr || add_acc;
    assign ram_wr_data = (state_q == LL_RUN) ? add_empty_ptr_i : init_cnt_q[A_WIDTH-1:0];

    always_comb begin
        state_d    = state_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        init_cnt_d = init_cnt_q;
        val_d      = val_q;
        err_d      = err_q;
        ram_cnt_d  = ram_cnt_q + (A_WIDTH+1)'(add_acc) - (A_WIDTH+1)'(rd_en);

        if (add_acc) begin
            wr_idx_d = wr_idx_q + A_WIDTH'(1);
        end
        if (rd_en) begin
            rd_idx_d = rd_idx_q + A_WIDTH'(1);
            val_d    = 1'b1;
        end else if (pop) begin
            val_d    = 1'b0;
        end

        if (next_empty_ptr_rd_ack_i && !val_q) begin
            err_d.unf = 1'b1;
        end

        case (state_q)
            LL_INIT: begin
                if (add_empty_ptr_en_i) begin
                    err_d.ovf = 1'b1;
                end
                if (INIT_CNT == 0) begin
                    state_d = LL_RUN;
                end else begin
                    wr_idx_d   = wr_idx_q + A_WIDTH'(1);
                    init_cnt_d = init_cnt_q + (A_WIDTH+1)'(1);
                    ram_cnt_d  = ram_cnt_q + (A_WIDTH+1)'(1);
                    if (init_cnt_q == INIT_LAST) begin
                        state_d = LL_RUN;
                    end
                end
            end
            LL_RUN: begin
                if (add_empty_ptr_en_i && !add_acc) begin
                    err_d.ovf = 1'b1;
                end
            end
            default: state_d = LL_INIT;
        endcase

        // Re-initialise wins over anything else presented in the same cycle.
        if (srst_i) begin
            state_d    = LL_INIT;
            wr_idx_d   = '0;
            rd_idx_d   = '0;
            ram_cnt_d  = '0;
            init_cnt_d = '0;
            val_d      = 1'b0;
            err_d      = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= LL_INIT;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            ram_cnt_q  <= '0;
            init_cnt_q <= '0;
            val_q      <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            ram_cnt_q  <= ram_cnt_d;
            init_cnt_q <= init_cnt_d;
            val_q      <= val_d;
            err_q      <= err_d;
        end
    end

    ll_ptr_ram #(
        .A_WIDTH (A_WIDTH)
    ) u_ram (
        .clk_i     (clk_i),
        .wr_en_i   (ram_wr_en),
        .wr_addr_i (wr_idx_q),
        .wr_data_i (ram_wr_data),
        .rd_en_i   (rd_en && !srst_i),
        .rd_addr_i (rd_idx_q),
        .rd_data_o (ram_rd_data)
    );

    assign next_empty_ptr_o     = val_q ? ram_rd_data : '0;
    assign next_empty_ptr_val_o = val_q;
    assign init_done_o          = (state_q == LL_RUN);
    assign free_cnt_o           = free_cnt;
    assign ovf_o                = err_q.ovf;
    assign unf_o                = err_q.unf;

endmodule

// File: tb/tb_ll_free_ptr_fifo.sv
// Bench for the free-pointer pool: table-driven control checks plus a pointer-order scoreboard.
module tb_ll_free_ptr_fifo;

    typedef struct {
        logic       add_en;
        logic [2:0] add_ptr;
        logic       ack;
        logic       exp_val;
        logic [3:0] exp_cnt;
        logic       exp_done;
        logic       exp_ovf;
        logic       exp_unf;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       srst    [2];
    logic [2:0] add_ptr [2];
    logic       add_en  [2];
    logic       ack     [2];
    logic [2:0] ptr_o   [2];
    logic       val_o   [2];
    logic       done_o  [2];
    logic [3:0] cnt_o   [2];
    logic       ovf_o   [2];
    logic       unf_o   [2];

    int n_vec;
    int n_err;
    int sb0[$];
    int sb1[$];
    vec_t tbl0[$];
    vec_t tbl1[$];

    ll_free_ptr_fifo #(.A_WIDTH(3), .INIT_CNT(8)) u_dut0 (
        .clk_i                   (clk),
        .rst_i                   (rst),
        .srst_i                  (srst[0]),
        .add_empty_ptr_i         (add_ptr[0]),
        .add_empty_ptr_en_i      (add_en[0]),
        .next_empty_ptr_rd_ack_i (ack[0]),
        .next_empty_ptr_o        (ptr_o[0]),
        .next_empty_ptr_val_o    (val_o[0]),
        .init_done_o             (done_o[0]),
        .free_cnt_o              (cnt_o[0]),
        .ovf_o                   (ovf_o[0]),
        .unf_o                   (unf_o[0])
    );

    ll_free_ptr_fifo #(.A_WIDTH(3), .INIT_CNT(4)) u_dut1 (
        .clk_i                   (clk),
        .rst_i                   (rst),
        .srst_i                  (srst[1]),
        .add_empty_ptr_i         (add_ptr[1]),
        .add_empty_ptr_en_i      (add_en[1]),
        .next_empty_ptr_rd_ack_i (ack[1]),
        .next_empty_ptr_o        (ptr_o[1]),
        .next_empty_ptr_val_o    (val_o[1]),
        .init_done_o             (done_o[1]),
        .free_cnt_o              (cnt_o[1]),
        .ovf_o                   (ovf_o[1]),
        .unf_o                   (unf_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic a, input int p, input logic k, input logic v,
                                input int c, input logic d, input logic o, input logic u);
        vec_t r;
        r.add_en   = a;
        r.add_ptr  = 3'(p);
        r.ack      = k;
        r.exp_val  = v;
        r.exp_cnt  = 4'(c);
        r.exp_done = d;
        r.exp_ovf  = o;
        r.exp_unf  = u;
        return r;
    endfunction

    task automatic idle_inputs();
        for (int i = 0; i < 2; i++) begin
            srst[i]    = 1'b0;
            add_en[i]  = 1'b0;
            add_ptr[i] = 3'd0;
            ack[i]     = 1'b0;
        end
    endtask

    task automatic check_reset_state(input int d, input string tag);
        check({tag, ".val"},  int'(val_o[d]),  0);
        check({tag, ".ptr"},  int'(ptr_o[d]),  0);
        check({tag, ".done"}, int'(done_o[d]), 0);
        check({tag, ".cnt"},  int'(cnt_o[d]),  0);
        check({tag, ".ovf"},  int'(ovf_o[d]),  0);
        check({tag, ".unf"},  int'(unf_o[d]),  0);
    endtask

    // Compare control outputs against the row, then pop the scoreboard on a delivered pointer.
    task automatic apply_vec(input int d, input vec_t v, input string tag);
        int   exp_ptr;
        int   sz;
        logic acc;
        check({tag, ".val"},  int'(val_o[d]),  int'(v.exp_val));
        check({tag, ".cnt"},  int'(cnt_o[d]),  int'(v.exp_cnt));
        check({tag, ".done"}, int'(done_o[d]), int'(v.exp_done));
        check({tag, ".ovf"},  int'(ovf_o[d]),  int'(v.exp_ovf));
        check({tag, ".unf"},  int'(unf_o[d]),  int'(v.exp_unf));
        if (v.ack && val_o[d]) begin
            sz = (d == 0) ? sb0.size() : sb1.size();
            if (sz == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL %s.sb: got pointer %0d, expected no pointer", tag, ptr_o[d]);
            end else begin
                if (d == 0) exp_ptr = sb0.pop_front();
                else        exp_ptr = sb1.pop_front();
                check({tag, ".ptr"}, int'(ptr_o[d]), exp_ptr);
            end
        end
        acc = v.add_en && v.exp_done && ((v.exp_cnt < 4'd8) || (v.ack && v.exp_val));
        if (acc) begin
            if (d == 0) sb0.push_back(int'(v.add_ptr));
            else        sb1.push_back(int'(v.add_ptr));
        end
        $display("[%s] dut%0d add=%0d ptr_in=%0d ack=%0d | val=%0d ptr=%0d cnt=%0d ovf=%0d unf=%0d",
                 tag, d, v.add_en, v.add_ptr, v.ack, val_o[d], ptr_o[d], cnt_o[d], ovf_o[d], unf_o[d]);
        add_en[d]  = v.add_en;
        add_ptr[d] = v.add_ptr;
        ack[d]     = v.ack;
        tick();
        add_en[d]  = 1'b0;
        ack[d]     = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        idle_inputs();
        rst = 1'b1;
        repeat (3) tick();
        check_reset_state(0, "por0");
        check_reset_state(1, "por1");

        // Preload: 8 INIT cycles for dut0, 4 for dut1.
        rst = 1'b0;
        repeat (7) tick();
        check("init7.done0", int'(done_o[0]), 0);
        check("init7.done1", int'(done_o[1]), 1);
        check("init7.cnt1",  int'(cnt_o[1]),  4);
        tick();
        check("init8.done0", int'(done_o[0]), 1);
        check("init8.cnt0",  int'(cnt_o[0]),  8);
        check("init8.val0",  int'(val_o[0]),  0);
        tick();
        for (int i = 0; i < 8; i++) sb0.push_back(i);
        for (int i = 0; i < 4; i++) sb1.push_back(i);

        // dut0: drain, add-to-empty latency, fill to full, overflow, add+pop when full, underflow.
        for (int i = 0; i < 8; i++) tbl0.push_back(mk(0, 0, 1, 1, 8 - i, 1, 0, 0));
        tbl0.push_back(mk(1, 5, 0, 0, 0, 1, 0, 0));
        tbl0.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
        tbl0.push_back(mk(0, 0, 1, 1, 1, 1, 0, 0));
        tbl0.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0));
        for (int i = 0; i < 8; i++) tbl0.push_back(mk(1, i, 0, (i >= 2), i, 1, 0, 0));
        tbl0.push_back(mk(1, 3, 0, 1, 8, 1, 0, 0));
        tbl0.push_back(mk(1, 3, 1, 1, 8, 1, 1, 0));
        for (int i = 0; i < 8; i++) tbl0.push_back(mk(0, 0, 1, 1, 8 - i, 1, 1, 0));
        tbl0.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0));
        tbl0.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1));
        foreach (tbl0[i]) apply_vec(0, tbl0[i], $sformatf("t0.%0d", i));
        check("t0.sb_left", sb0.size(), 0);

        // dut1 (INIT_CNT=4): pop 0,1, return 6,2, then expect 2,3,6,2 and an underflow.
        tbl1.push_back(mk(0, 0, 1, 1, 4, 1, 0, 0));
        tbl1.push_back(mk(0, 0, 1, 1, 3, 1, 0, 0));
        tbl1.push_back(mk(1, 6, 0, 1, 2, 1, 0, 0));
        tbl1.push_back(mk(1, 2, 0, 1, 3, 1, 0, 0));
        for (int i = 0; i < 4; i++) tbl1.push_back(mk(0, 0, 1, 1, 4 - i, 1, 0, 0));
        tbl1.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0));
        tbl1.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1));
        foreach (tbl1[i]) apply_vec(1, tbl1[i], $sformatf("t1.%0d", i));
        check("t1.sb_left", sb1.size(), 0);

        // srst in RUN with add+ack in the same cycle: srst wins, flags clear.
        srst[0]    = 1'b1;
        add_en[0]  = 1'b1;
        add_ptr[0] = 3'd4;
        ack[0]     = 1'b1;
        tick();
        idle_inputs();
        $display("[srst] dut0 re-initialise issued");
        check("srst.done", int'(done_o[0]), 0);
        check("srst.val",  int'(val_o[0]),  0);
        check("srst.cnt",  int'(cnt_o[0]),  0);
        check("srst.ovf",  int'(ovf_o[0]),  0);
        check("srst.unf",  int'(unf_o[0]),  0);

        // Async reset pulse three cycles into the preload.
        repeat (3) tick();
        check("midinit.done", int'(done_o[0]), 0);
        rst = 1'b1;
        #1;
        $display("[rst] async reset asserted mid-INIT");
        check_reset_state(0, "midrst");
        @(negedge clk);
        rst = 1'b0;
        repeat (7) tick();
        check("reinit7.done", int'(done_o[0]), 0);
        tick();
        check("reinit8.done", int'(done_o[0]), 1);
        check("reinit8.cnt",  int'(cnt_o[0]),  8);
        tick();
        sb0.delete();
        for (int i = 0; i < 8; i++) sb0.push_back(i);
        apply_vec(0, mk(0, 0, 1, 1, 8, 1, 0, 0), "re.0");
        apply_vec(0, mk(0, 0, 1, 1, 7, 1, 0, 0), "re.1");

        // Add and ack during INIT are dropped and flagged.
        srst[0] = 1'b1;
        tick();
        srst[0]   = 1'b0;
        add_en[0] = 1'b1;
        add_ptr[0] = 3'd6;
        ack[0]    = 1'b1;
        $display("[init] dut0 add+ack during INIT");
        tick();
        idle_inputs();
        check("initerr.ovf",  int'(ovf_o[0]),  1);
        check("initerr.unf",  int'(unf_o[0]),  1);
        check("initerr.done", int'(done_o[0]), 0);
        check("initerr.val",  int'(val_o[0]),  0);
        repeat (7) tick();
        check("initerr.done8", int'(done_o[0]), 1);
        check("initerr.cnt8",  int'(cnt_o[0]),  8);
        tick();
        check("initerr.val9", int'(val_o[0]), 1);
        check("initerr.ptr9", int'(ptr_o[0]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
